// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Contents: format codes, NOP word, common opcodes, request payload struct.
// Optional feature macro used by the encoder: INSTR_ENC_RANGE_CHECK_EN.
package rv_enc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned REG_W = 5;

    localparam logic [FMT_W-1:0] FMT_R    = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_ISH  = 3'd2;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd5;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd6;
    localparam logic [FMT_W-1:0] FMT_RSVD = 3'd7;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;

    // One encode request as captured by the first pipeline stage
    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } enc_req_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: request fields + 32-bit immediate -> RV32I word.
// Ports:
//   req         in   enc_req_t  request fields
//   instr_c     out  32         packed word (NOP whenever range_err_c is set)
//   range_err_c out  1          reserved format or (with INSTR_ENC_RANGE_CHECK_EN) bad immediate
// Macro INSTR_ENC_RANGE_CHECK_EN enables immediate range checking; without it the
// immediate is silently truncated to the bits each format carries.
module instr_pack
    import rv_enc_pkg::*;
(
    input  enc_req_t          req,
    output logic [XLEN-1:0]   instr_c,
    output logic              range_err_c
);

    logic [XLEN-1:0] word_c;
    logic            err_c;
    logic [XLEN-1:0] imm;

    assign imm = req.imm;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Sign-extension tests: upper bits must all equal the sign bit of the field
    logic fits12_c;
    logic fits13_c;
    logic fits21_c;
    assign fits12_c = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13_c = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21_c = (imm[31:20] == '0) || (imm[31:20] == '1);
`endif

    // Format-specific bit placement
    always_comb begin
        word_c = NOP_INSTR;
        err_c  = 1'b0;
        case (req.fmt)
            FMT_R: begin
                word_c = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            FMT_I: begin
                word_c = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = !fits12_c;
`endif
            end
            FMT_ISH: begin
                word_c = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = (imm[31:5] != '0);
`endif
            end
            FMT_S: begin
                word_c = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = !fits12_c;
`endif
            end
            FMT_B: begin
                word_c = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                          imm[4:1], imm[11], req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = !fits13_c || imm[0];
`endif
            end
            FMT_U: begin
                word_c = {imm[31:12], req.rd, req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = (imm[11:0] != '0);
`endif
            end
            FMT_J: begin
                word_c = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                err_c  = !fits21_c || imm[0];
`endif
            end
            default: begin
                word_c = NOP_INSTR;
                err_c  = 1'b1;
            end
        endcase
    end

    // Any rejected request is replaced by a NOP so memory never sees a half-valid word
    assign instr_c     = err_c ? NOP_INSTR : word_c;
    assign range_err_c = err_c;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with encode/error counters.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             request handshake (in_ready is combinational from out_ready)
//   in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm  request fields
//   out_valid/out_ready           result handshake
//   out_instr, out_err            encoded word and error flag (registered)
//   enc_count                     completed output handshakes, wrapping
//   err_count                     handshakes with out_err set, saturating
// Macro INSTR_ENC_RANGE_CHECK_EN (consumed by instr_pack) enables immediate range checks.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FMT_W-1:0]  in_fmt,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [F3_W-1:0]   in_funct3,
    input  logic [F7_W-1:0]   in_funct7,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic              out_err,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  err_count
);

    enc_req_t          in_req_c;
    logic              s1_valid_q, s1_valid_d;
    enc_req_t          s1_req_q, s1_req_d;
    logic              s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]   s2_instr_q, s2_instr_d;
    logic              s2_err_q, s2_err_d;
    logic [CNT_W-1:0]  enc_count_q, enc_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic              s1_adv_c;
    logic              s2_adv_c;
    logic              out_fire_c;
    logic [XLEN-1:0]   pack_instr_c;
    logic              pack_err_c;

    assign in_req_c = '{fmt:    in_fmt,
                        opcode: in_opcode,
                        funct3: in_funct3,
                        funct7: in_funct7,
                        rd:     in_rd,
                        rs1:    in_rs1,
                        rs2:    in_rs2,
                        imm:    in_imm};

    // A stage may take new data when empty or when its content moves on this cycle
    assign s2_adv_c   = !s2_valid_q || out_ready;
    assign s1_adv_c   = !s1_valid_q || s2_adv_c;
    assign out_fire_c = s2_valid_q && out_ready;

    instr_pack u_pack (
        .req         (s1_req_q),
        .instr_c     (pack_instr_c),
        .range_err_c (pack_err_c)
    );

    // Next-state for pipeline stages and counters
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_req_d    = s1_req_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (s1_adv_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_req_d = in_req_c;
            end
        end

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pack_instr_c;
                s2_err_d   = pack_err_c;
            end
        end

        if (out_fire_c) begin
            enc_count_d = enc_count_q + CNT_W'(1);
            if (s2_err_q && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = s1_adv_c;
    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table + scoreboard queue,
// plus hand sequences for latency, backpressure, saturation and mid-run reset.
module tb_instr_encoder;
    import rv_enc_pkg::*;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned NVEC  = 19;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] instr_nc;
        logic        err_nc;
        logic [31:0] instr_rc;
        logic        err_rc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic              out_err;
    logic [CNT_W-1:0]  enc_count;
    logic [CNT_W-1:0]  err_count;

    vec_t              tbl [NVEC];
    exp_t              sb [$];
    exp_t              cur_exp;
    exp_t              held;
    logic              held_valid;
    logic              last_in_fire;
    logic              rand_bp;
    logic [CNT_W-1:0]  exp_enc;
    logic [CNT_W-1:0]  exp_err;
    logic [CNT_W-1:0]  enc_before;
    int                n_vec;
    int                n_fail;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [2:0] fmt, logic [6:0] op, logic [2:0] f3,
                                logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic [31:0] inc, logic enc,
                                logic [31:0] irc, logic erc);
        vec_t v;
        v.name = nm; v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.instr_nc = inc; v.err_nc = enc; v.instr_rc = irc; v.err_rc = erc;
        return v;
    endfunction

    function automatic exp_t pick(vec_t v);
        exp_t e;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        e.instr = v.instr_rc;
        e.err   = v.err_rc;
`else
        e.instr = v.instr_nc;
        e.err   = v.err_nc;
`endif
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        cur_exp   = pick(v);
    endtask

    // One cycle: settle, score both handshakes, advance to the next falling edge
    task automatic step();
        exp_t e;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        #1;
        if (held_valid) begin
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_instr", out_instr, held.instr);
            chk("stall_hold_err", 32'(out_err), 32'(held.err));
        end
        held_valid = out_valid && !out_ready;
        held.instr = out_instr;
        held.err   = out_err;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with no request pending", out_instr);
            end else begin
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_err", 32'(out_err), 32'(e.err));
                chk("enc_count", 32'(enc_count), 32'(exp_enc));
                chk("err_count", 32'(err_count), 32'(exp_err));
                exp_enc = CNT_W'(exp_enc + 1'b1);
                if (e.err && (exp_err != '1)) exp_err = CNT_W'(exp_err + 1'b1);
            end
        end
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) sb.push_back(cur_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_in_fire) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_ready within 50 cycles, expected acceptance");
    endtask

    task automatic drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (sb.size() == 0 && !out_valid) return;
            step();
        end
        n_vec++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rand_bp = 1'b0;
        in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        held_valid = 1'b0; last_in_fire = 1'b0; exp_enc = '0; exp_err = '0;
        cur_exp = '0; held = '0;

        tbl[0]  = mk("addi",     FMT_I,    OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0, 32'h00500093, 1'b0);
        tbl[1]  = mk("sw",       FMT_S,    OPC_STORE,  3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0, 32'h0020A423, 1'b0);
        tbl[2]  = mk("beq_m4",   FMT_B,    OPC_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 32'hFE000EE3, 1'b0);
        tbl[3]  = mk("sub",      FMT_R,    OPC_OP,     3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0, 32'h402081B3, 1'b0);
        tbl[4]  = mk("srai",     FMT_ISH,  OPC_OP_IMM, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293, 1'b0, 32'h40335293, 1'b0);
        tbl[5]  = mk("lui",      FMT_U,    OPC_LUI,    3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b0, 32'h123453B7, 1'b0);
        tbl[6]  = mk("lui_low",  FMT_U,    OPC_LUI,    3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'h12345678, 32'h123453B7, 1'b0, NOP_INSTR,    1'b1);
        tbl[7]  = mk("jal_2048", FMT_J,    OPC_JAL,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0, 32'h001000EF, 1'b0);
        tbl[8]  = mk("jal_m2",   FMT_J,    OPC_JAL,    3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0, 32'hFFFFF06F, 1'b0);
        tbl[9]  = mk("addi_2048",FMT_I,    OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b0, NOP_INSTR,    1'b1);
        tbl[10] = mk("addi_m2048",FMT_I,   OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0, 32'h80000093, 1'b0);
        tbl[11] = mk("slli_32",  FMT_ISH,  OPC_OP_IMM, 3'd1, 7'h00, 5'd1, 5'd0, 5'd0, 32'd32,       32'h00001093, 1'b0, NOP_INSTR,    1'b1);
        tbl[12] = mk("beq_odd",  FMT_B,    OPC_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b0, NOP_INSTR,    1'b1);
        tbl[13] = mk("rsvd",     FMT_RSVD, OPC_OP,     3'd7, 7'h7F, 5'd31,5'd31,5'd31,32'hFFFFFFFF, NOP_INSTR,    1'b1, NOP_INSTR,    1'b1);
        tbl[14] = mk("addi_m1",  FMT_I,    OPC_OP_IMM, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFF08093, 1'b0, 32'hFFF08093, 1'b0);
        tbl[15] = mk("jal_2p20", FMT_J,    OPC_JAL,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, 1'b0, NOP_INSTR,    1'b1);
        tbl[16] = mk("beq_4094", FMT_B,    OPC_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0, 32'h7E000FE3, 1'b0);
        tbl[17] = mk("sw_m2048", FMT_S,    OPC_STORE,  3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF800, 32'h8020A023, 1'b0, 32'h8020A023, 1'b0);
        tbl[18] = mk("sw_2048",  FMT_S,    OPC_STORE,  3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd2048,     32'h8020A023, 1'b0, NOP_INSTR,    1'b1);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: word appears two edges after acceptance
        out_ready = 1'b1;
        drive(tbl[0]);
        wait_accept();
        in_valid = 1'b0;
        #1 chk("lat_not_yet", 32'(out_valid), 32'd0);
        step();
        #1 chk("lat_valid", 32'(out_valid), 32'd1);
        drain();

        // Table, back-to-back with a free consumer
        out_ready = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i]);
            wait_accept();
        end
        in_valid = 1'b0;
        drain();

        // Table again under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i]);
            wait_accept();
        end
        in_valid = 1'b0;
        drain();

        // Three requests into a stalled consumer
        enc_before = exp_enc;
        out_ready  = 1'b0;
        drive(tbl[0]);
        wait_accept();
        drive(tbl[1]);
        wait_accept();
        drive(tbl[2]);
        #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        drain();
        chk("stall_enc_count", 32'(enc_count), 32'(CNT_W'(enc_before + 2'd3)));

        // Error counter saturation with reserved-format requests
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[13]);
            wait_accept();
        end
        in_valid = 1'b0;
        drain();
        chk("err_saturated", 32'(err_count), 32'd3);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(tbl[3]);
        wait_accept();
        drive(tbl[4]);
        wait_accept();
        in_valid = 1'b0;
        #1 chk("pre_rst_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_enc_count", 32'(enc_count), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        sb.delete();
        exp_enc = '0;
        exp_err = '0;
        held_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("postrst_quiet", 32'(out_valid), 32'd0);

        // Encoder still works after the reset
        drive(tbl[1]);
        wait_accept();
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
